// File: rtl/stack_exec_unit.sv
// rtl/stack_exec_unit.sv - execute stage running decoded stack-machine instructions
module stack_exec_unit #(
  parameter int DATA_LEN = 8,
  parameter int ADDR_LEN = 8,
  parameter int INST_CAP = 20,
  parameter int PC_W     = $clog2(INST_CAP) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [3:0]          control_bus,
  input  logic [DATA_LEN-1:0] addr_const,
  output logic [PC_W-1:0]     pc,
  output logic                fin_sig,
  output logic                halted,
  output logic                err,
  output logic [DATA_LEN-1:0] stk_data_in,
  output logic                stk_push,
  output logic                stk_pop,
  input  logic [DATA_LEN-1:0] stk_data_out,
  input  logic                stk_full,
  input  logic                stk_empty,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic [DATA_LEN-1:0] mem_data_in,
  input  logic [DATA_LEN-1:0] mem_data_out
);
  localparam logic [3:0] OP_PUSH  = 4'h1;
  localparam logic [3:0] OP_PUSHC = 4'h2;
  localparam logic [3:0] OP_POP   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [DATA_LEN-1:0] CAP_D   = DATA_LEN'(INST_CAP);
  localparam logic [PC_W-1:0]     LAST_PC = PC_W'(INST_CAP - 1);

  typedef enum logic [2:0] {IDLE, POPA, POPB, MRD, MWAIT, PUSH, WRITE, DONE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          op;
  logic [DATA_LEN-1:0] operand, a, b, result;
  logic                aborted;
  logic                start;
  logic                jump_taken;

  assign start      = (state == IDLE) && en && !halted;
  // An underflowed JZ never saw a valid top, so it must fall through.
  assign jump_taken = (op == OP_JMP) || ((op == OP_JZ) && !aborted && (a == '0));

  // Value pushed in PUSH; b is the deeper operand, a the first one popped.
  always_comb begin
    result = a;
    case (op)
      OP_PUSHC: result = operand;
      OP_ADD:   result = b + a;
      OP_SUB:   result = b - a;
      OP_AND:   result = b & a;
      OP_OR:    result = b | a;
      OP_NOT:   result = ~a;
      default:  result = a;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded strobes; stack strobes are suppressed on empty/full.
  always_comb begin
    state_nxt   = state;
    fin_sig     = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    mem_r_en    = 1'b0;
    mem_w_en    = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    case (state)
      IDLE: begin
        if (start) begin
          case (control_bus)
            OP_PUSH:  state_nxt = MRD;
            OP_PUSHC: state_nxt = PUSH;
            OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_JZ: state_nxt = POPA;
            default:  state_nxt = DONE;
          endcase
        end
      end
      POPA: begin
        stk_pop = !stk_empty;
        if (stk_empty) state_nxt = DONE;
        else begin
          case (op)
            OP_POP:                         state_nxt = WRITE;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  state_nxt = POPB;
            OP_NOT:                         state_nxt = PUSH;
            default:                        state_nxt = DONE;
          endcase
        end
      end
      POPB: begin
        stk_pop   = !stk_empty;
        state_nxt = stk_empty ? DONE : PUSH;
      end
      MRD: begin
        mem_r_en  = 1'b1;
        mem_addr  = ADDR_LEN'(operand);
        state_nxt = MWAIT;
      end
      MWAIT: state_nxt = PUSH;
      PUSH: begin
        stk_push    = !stk_full;
        stk_data_in = result;
        state_nxt   = DONE;
      end
      WRITE: begin
        mem_w_en    = 1'b1;
        mem_addr    = ADDR_LEN'(operand);
        mem_data_in = a;
        state_nxt   = DONE;
      end
      DONE: begin
        fin_sig   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction capture, operand registers, sticky flags and program counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op      <= '0;
      operand <= '0;
      a       <= '0;
      b       <= '0;
      aborted <= 1'b0;
      pc      <= '0;
      err     <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op      <= control_bus;
            operand <= addr_const;
            aborted <= 1'b0;
          end
        end
        POPA: begin
          if (stk_empty) begin
            err     <= 1'b1;
            aborted <= 1'b1;
          end else a <= stk_data_out;
        end
        POPB: begin
          if (stk_empty) begin
            err     <= 1'b1;
            aborted <= 1'b1;
          end else b <= stk_data_out;
        end
        MWAIT: a <= mem_data_out;
        PUSH:  if (stk_full) err <= 1'b1;
        DONE: begin
          if (op == OP_HALT) halted <= 1'b1;
          else if (jump_taken) begin
            if (operand >= CAP_D) begin
              pc  <= '0;
              err <= 1'b1;
            end else pc <= PC_W'(operand);
          end else pc <= (pc == LAST_PC) ? '0 : pc + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
